microwave_controller: RTL and testbench

- Sequencing controller for the microwave. Consumes the keypad encoder's BCD digit stream (D/load) and its 1 Hz tick (pgt_1hz).
- Drives the encoder's enable. Holds the MM:SS cook time, runs the cook/pause/done state machine and gates the magnetron.
- Sits between the encoder and the display/power stages.

---
 rtl/microwave_pkg.sv | 18 +
 rtl/microwave_if.sv | 13 +
 rtl/microwave_bcd_mmss_down_counter.sv | 62 ++++++
 rtl/microwave_controller.sv | 145 ++++++++++++++
 tb/tb_microwave_controller.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller slice.
package microwave_pkg;

   typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } mmss_t;

   localparam bcd_t  BCD_MAX          = 4'd9;
   localparam mmss_t QUICK_START_TIME = '{min_tens: 4'd0, min_ones: 4'd0, sec_tens: 4'd3, sec_ones: 4'd0};

endpackage

// File: rtl/microwave_if.sv
// Link between the keypad encoder (master) and the microwave controller (slave).
interface microwave_if;
   import microwave_pkg::*;

   bcd_t d;
   logic load;
   logic pgt_1hz;
   logic enable;

   modport master (output d, output load, output pgt_1hz, input enable);
   modport slave  (input d, input load, input pgt_1hz, output enable);

endinterface

// File: rtl/microwave_bcd_mmss_down_counter.sv
// Four-digit MM:SS BCD register with shift-in load, clear, preset and borrow-wrapping decrement.
module bcd_mmss_down_counter
   import microwave_pkg::*;
#(
   parameter int unsigned MAX_MIN_TENS = 9
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  shift_en,
   input  bcd_t  shift_d,
   input  logic  clear,
   input  logic  preset,
   input  mmss_t preset_val,
   input  logic  dec,
   output mmss_t time_q,
   output logic  is_zero,
   output logic  is_one
);

   mmss_t time_d;

   always_comb begin
      time_d = time_q;
      if (clear) begin
         time_d = '0;
      end else if (preset) begin
         time_d = preset_val;
      end else if (dec) begin
         // Non-normalised seconds (e.g. 99) count down digit-wise; wrap to 5 only on a borrow out of sec_tens.
         if (time_q.sec_ones != '0) begin
            time_d.sec_ones = time_q.sec_ones - 4'd1;
         end else begin
            time_d.sec_ones = 4'd9;
            if (time_q.sec_tens != '0) begin
               time_d.sec_tens = time_q.sec_tens - 4'd1;
            end else begin
               time_d.sec_tens = 4'd5;
               if (time_q.min_ones != '0) begin
                  time_d.min_ones = time_q.min_ones - 4'd1;
               end else begin
                  time_d.min_ones = 4'd9;
                  time_d.min_tens = time_q.min_tens - 4'd1;
               end
            end
         end
      end else if (shift_en && (shift_d <= BCD_MAX) && ({28'd0, time_q.min_ones} <= MAX_MIN_TENS)) begin
         time_d = {time_q.min_ones, time_q.sec_tens, time_q.sec_ones, shift_d};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_q <= '0;
      end else begin
         time_q <= time_d;
      end
   end

   assign is_zero = (time_q == mmss_t'(16'h0000));
   assign is_one  = (time_q == mmss_t'(16'h0001));

endmodule

// File: rtl/microwave_controller.sv
// Microwave cook/pause/done sequencer driving the encoder enable and magnetron.
// Optional MICROWAVE_QUICK_START_EN: start at 0000 with the door closed cooks for 0030.
module microwave_controller
   import microwave_pkg::*;
#(
   parameter int unsigned DONE_TICKS   = 3,
   parameter int unsigned MAX_MIN_TENS = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   microwave_if.slave       enc,
   input  logic             start,
   input  logic             stop_clear,
   input  logic             door_closed,
   output logic             mag_on,
   output logic             done,
   output bcd_t             min_tens,
   output bcd_t             min_ones,
   output bcd_t             sec_tens,
   output bcd_t             sec_ones
);

   localparam int unsigned TW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DONE_TICKS - 1);

   state_t        state_q, state_d;
   logic [TW-1:0] tick_cnt, tick_cnt_d;
   logic          start_q, stop_q, start_p, stop_p;
   logic          shift_en, clear, preset, dec;
   logic          is_zero, is_one;
   mmss_t         time_q;

   bcd_mmss_down_counter #(
      .MAX_MIN_TENS (MAX_MIN_TENS)
   ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en   (shift_en),
      .shift_d    (enc.d),
      .clear      (clear),
      .preset     (preset),
      .preset_val (QUICK_START_TIME),
      .dec        (dec),
      .time_q     (time_q),
      .is_zero    (is_zero),
      .is_one     (is_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         start_p <= 1'b0;
         stop_p  <= 1'b0;
      end else begin
         start_q <= start;
         stop_q  <= stop_clear;
         start_p <= start & ~start_q;
         stop_p  <= stop_clear & ~stop_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = '0;
      shift_en   = 1'b0;
      clear      = 1'b0;
      preset     = 1'b0;
      dec        = 1'b0;
      case (state_q)
         IDLE: begin
            if (stop_p) begin
               clear = 1'b1;
            end else if (start_p && door_closed && !is_zero) begin
               state_d = COOK;
`ifdef MICROWAVE_QUICK_START_EN
            end else if (start_p && door_closed) begin
               preset  = 1'b1;
               state_d = COOK;
`endif
            end else begin
               shift_en = enc.load;
            end
         end
         COOK: begin
            if (stop_p || !door_closed) begin
               state_d = PAUSE;
            end else if (enc.pgt_1hz) begin
               if (is_one || is_zero) begin
                  clear   = 1'b1;
                  state_d = DONE;
               end else begin
                  dec = 1'b1;
               end
            end
         end
         PAUSE: begin
            if (stop_p) begin
               clear   = 1'b1;
               state_d = IDLE;
            end else if (start_p && door_closed) begin
               state_d = COOK;
            end
         end
         DONE: begin
            tick_cnt_d = tick_cnt;
            if (stop_p || !door_closed) begin
               state_d    = IDLE;
               tick_cnt_d = '0;
            end else if (enc.pgt_1hz) begin
               if (tick_cnt == TICK_LAST) begin
                  state_d    = IDLE;
                  tick_cnt_d = '0;
               end else begin
                  tick_cnt_d = tick_cnt + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt   <= '0;
         mag_on     <= 1'b0;
         done       <= 1'b0;
         enc.enable <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt   <= tick_cnt_d;
         mag_on     <= (state_d == COOK);
         done       <= (state_d == DONE);
         enc.enable <= (state_d == COOK) || (state_d == DONE);
      end
   end

   assign min_tens = time_q.min_tens;
   assign min_ones = time_q.min_ones;
   assign sec_tens = time_q.sec_tens;
   assign sec_ones = time_q.sec_ones;

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench for microwave_controller: directed scenarios plus randomized run against a behavioural model.
module tb_microwave_controller;

   localparam int DONE_TICKS   = 3;
   localparam int MAX_MIN_TENS = 9;
   localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, stop_clear = 1'b0, door_closed = 1'b1;
   logic mag_on, done;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   int errors = 0;
   int checks = 0;

   // Behavioural model state: time held as a 4-digit decimal number MMSS.
   int   m_mode, m_t, m_cnt;
   logic m_s1, m_s2, m_c1, m_c2;

   microwave_if enc();

   always #5 clk = ~clk;

   microwave_controller #(
      .DONE_TICKS   (DONE_TICKS),
      .MAX_MIN_TENS (MAX_MIN_TENS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enc         (enc),
      .start       (start),
      .stop_clear  (stop_clear),
      .door_closed (door_closed),
      .mag_on      (mag_on),
      .done        (done),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones)
   );

   function automatic logic [15:0] shown();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic do_reset();
      start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
      enc.d = 4'd0; enc.load = 1'b0; enc.pgt_1hz = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_digit(input logic [3:0] v);
      enc.d = v; enc.load = 1'b1;
      @(negedge clk);
      enc.load = 1'b0;
   endtask

   task automatic set_time(input logic [15:0] t);
      for (int i = 3; i >= 0; i--) load_digit(t[4*i +: 4]);
   endtask

   task automatic press_start();
      start = 1'b1;
      @(negedge clk); @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_stop();
      stop_clear = 1'b1;
      @(negedge clk); @(negedge clk);
      stop_clear = 1'b0;
      @(negedge clk);
   endtask

   task automatic tick();
      enc.pgt_1hz = 1'b1;
      @(negedge clk);
      enc.pgt_1hz = 1'b0;
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_t = 0; m_cnt = 0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_c1 = 1'b0; m_c2 = 1'b0;
   endtask

   task automatic model_step(input logic st, input logic sc, input logic door,
                             input logic ld, input int dv, input logic tk);
      logic sp, cp;
      int mm, ss;
      sp = m_s1 && !m_s2;
      cp = m_c1 && !m_c2;
      m_s2 = m_s1; m_s1 = st;
      m_c2 = m_c1; m_c1 = sc;
      case (m_mode)
         M_IDLE: begin
            if (cp) m_t = 0;
            else if (sp && door && m_t != 0) m_mode = M_COOK;
`ifdef MICROWAVE_QUICK_START_EN
            else if (sp && door) begin m_t = 30; m_mode = M_COOK; end
`endif
            else if (ld && dv <= 9 && (m_t / 100) % 10 <= MAX_MIN_TENS) m_t = (m_t % 1000) * 10 + dv;
         end
         M_COOK: begin
            if (cp || !door) m_mode = M_PAUSE;
            else if (tk) begin
               if (m_t <= 1) begin m_t = 0; m_mode = M_DONE; m_cnt = 0; end
               else begin
                  mm = m_t / 100; ss = m_t % 100;
                  if (ss > 0) ss--; else begin ss = 59; mm--; end
                  m_t = mm * 100 + ss;
               end
            end
         end
         M_PAUSE: begin
            if (cp) begin m_t = 0; m_mode = M_IDLE; end
            else if (sp && door) m_mode = M_COOK;
         end
         default: begin
            if (cp || !door) m_mode = M_IDLE;
            else if (tk) begin
               m_cnt++;
               if (m_cnt >= DONE_TICKS) m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   task automatic test_reset();
      enc.d = 4'd0; enc.load = 1'b0; enc.pgt_1hz = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL reset_mag_on: got %b expected 0", mag_on); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (enc.enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enc.enable); end
      checks++; if (shown() !== 16'h0000) begin errors++; $display("FAIL reset_time: got %h expected 0000", shown()); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load_start();
      do_reset();
      load_digit(4'd1); load_digit(4'd3); load_digit(4'd0);
      checks++; if (shown() !== 16'h0130) begin errors++; $display("FAIL load_0130: got %h expected 0130", shown()); end
      start = 1'b1;
      @(negedge clk);
      checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL start_latency: got mag_on=%b expected 0", mag_on); end
      @(negedge clk);
      checks++; if ({mag_on, enc.enable} !== 2'b11) begin errors++; $display("FAIL start_cook: got mag_on,enable=%b expected 11", {mag_on, enc.enable}); end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_decrement();
      do_reset();
      set_time(16'h0100);
      // tick coincides with the IDLE->COOK edge and must be ignored
      start = 1'b1;
      @(negedge clk);
      enc.pgt_1hz = 1'b1;
      @(negedge clk);
      enc.pgt_1hz = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++; if (shown() !== 16'h0100 || mag_on !== 1'b1) begin errors++; $display("FAIL start_tick_ignored: got %h mag_on=%b expected 0100 1", shown(), mag_on); end
      tick();
      checks++; if (shown() !== 16'h0059) begin errors++; $display("FAIL dec_0100: got %h expected 0059", shown()); end
      tick();
      checks++; if (shown() !== 16'h0058) begin errors++; $display("FAIL dec_0059: got %h expected 0058", shown()); end
      do_reset();
      set_time(16'h1000);
      press_start();
      tick();
      checks++; if (shown() !== 16'h0959) begin errors++; $display("FAIL dec_1000: got %h expected 0959", shown()); end
      do_reset();
      set_time(16'h0099);
      press_start();
      tick();
      checks++; if (shown() !== 16'h0098) begin errors++; $display("FAIL dec_0099: got %h expected 0098", shown()); end
   endtask

   task automatic test_done();
      do_reset();
      set_time(16'h0002);
      press_start();
      tick();
      checks++; if (shown() !== 16'h0001 || mag_on !== 1'b1) begin errors++; $display("FAIL done_0001: got %h mag_on=%b expected 0001 1", shown(), mag_on); end
      tick();
      checks++; if ({shown(), done, mag_on, enc.enable} !== {16'h0000, 3'b101}) begin errors++; $display("FAIL done_enter: got %h d/m/e=%b expected 0000 101", shown(), {done, mag_on, enc.enable}); end
      tick(); tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b expected 1", done); end
      tick();
      checks++; if ({done, mag_on, enc.enable} !== 3'b000) begin errors++; $display("FAIL done_exit: got d/m/e=%b expected 000", {done, mag_on, enc.enable}); end
      do_reset();
      set_time(16'h0001);
      press_start();
      tick();
      door_closed = 1'b0;
      @(negedge clk);
      checks++; if ({done, enc.enable} !== 2'b00) begin errors++; $display("FAIL done_door_open: got done,enable=%b expected 00", {done, enc.enable}); end
      door_closed = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pause();
      do_reset();
      set_time(16'h0045);
      press_start();
      door_closed = 1'b0;
      @(negedge clk);
      checks++; if ({mag_on, enc.enable} !== 2'b00) begin errors++; $display("FAIL pause_enter: got mag_on,enable=%b expected 00", {mag_on, enc.enable}); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (shown() !== 16'h0045) begin errors++; $display("FAIL pause_hold: got %h expected 0045", shown()); end
      door_closed = 1'b1;
      @(negedge clk);
      press_start();
      checks++; if (mag_on !== 1'b1) begin errors++; $display("FAIL pause_resume: got %b expected 1", mag_on); end
      tick();
      checks++; if (shown() !== 16'h0044) begin errors++; $display("FAIL resume_dec: got %h expected 0044", shown()); end
      press_stop();
      checks++; if (mag_on !== 1'b0 || shown() !== 16'h0044) begin errors++; $display("FAIL stop_to_pause: got %h mag_on=%b expected 0044 0", shown(), mag_on); end
      press_stop();
      checks++; if (shown() !== 16'h0000 || enc.enable !== 1'b0) begin errors++; $display("FAIL stop_clear: got %h enable=%b expected 0000 0", shown(), enc.enable); end
      press_start();
      checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL stopped_idle: got %b expected 0", mag_on); end
   endtask

   task automatic test_priority();
      do_reset();
      set_time(16'h0010);
      start = 1'b1; stop_clear = 1'b1;
      @(negedge clk); @(negedge clk);
      start = 1'b0; stop_clear = 1'b0;
      @(negedge clk);
      checks++; if (mag_on !== 1'b0 || shown() !== 16'h0000) begin errors++; $display("FAIL start_stop_same: got %h mag_on=%b expected 0000 0", shown(), mag_on); end
      set_time(16'h0010);
      load_digit(4'd12);
      checks++; if (shown() !== 16'h0010) begin errors++; $display("FAIL load_d12: got %h expected 0010", shown()); end
      load_digit(4'd9);
      checks++; if (shown() !== 16'h0109) begin errors++; $display("FAIL load_d9: got %h expected 0109", shown()); end
      press_start();
      load_digit(4'd5);
      checks++; if (shown() !== 16'h0109) begin errors++; $display("FAIL load_in_cook: got %h expected 0109", shown()); end
   endtask

   task automatic test_quick_start();
      do_reset();
      press_start();
`ifdef MICROWAVE_QUICK_START_EN
      checks++; if (mag_on !== 1'b1 || shown() !== 16'h0030) begin errors++; $display("FAIL quick_start: got %h mag_on=%b expected 0030 1", shown(), mag_on); end
`else
      checks++; if (mag_on !== 1'b0 || shown() !== 16'h0000) begin errors++; $display("FAIL zero_start: got %h mag_on=%b expected 0000 0", shown(), mag_on); end
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      set_time(16'h0020);
      press_start();
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({mag_on, enc.enable} !== 2'b00 || shown() !== 16'h0000) begin errors++; $display("FAIL async_reset: got %h mag_on,enable=%b expected 0000 00", shown(), {mag_on, enc.enable}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      int dut_t;
      logic [2:0] exp_flags;
      do_reset();
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) start = ~start;
         if ($urandom_range(0, 29) == 0) stop_clear = ~stop_clear;
         if ($urandom_range(0, 49) == 0) door_closed = ~door_closed;
         enc.load    = ($urandom_range(0, 2) == 0);
         enc.d       = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         enc.pgt_1hz = ($urandom_range(0, 3) == 0);
         @(posedge clk);
         model_step(start, stop_clear, door_closed, enc.load, int'(enc.d), enc.pgt_1hz);
         @(negedge clk);
         dut_t = int'(min_tens) * 1000 + int'(min_ones) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
         exp_flags = {m_mode == M_COOK, m_mode == M_DONE, m_mode == M_COOK || m_mode == M_DONE};
         checks++;
         if ({mag_on, done, enc.enable} !== exp_flags || dut_t != m_t) begin
            errors++;
            $display("FAIL random_cycle_%0d: got time=%0d m/d/e=%b expected time=%0d m/d/e=%b", i, dut_t, {mag_on, done, enc.enable}, m_t, exp_flags);
         end
      end
      start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
      enc.load = 1'b0; enc.pgt_1hz = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_start();
      test_decrement();
      test_done();
      test_pause();
      test_priority();
      test_quick_start();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
